// File: rtl/issue_queue_pkg.sv
// Shared defines for the issue queue: entry type, bool, default depth.
package issue_queue_pkg;

  typedef logic bool;

  typedef struct packed {
    logic [5:0]  rob_id;
    logic [31:0] pc;
    logic [15:0] uop;
  } ISSUE_QUEUE_ELEMENT;

  localparam int IQ_DEPTH_DEFAULT = 8;

endpackage

// File: rtl/issue_queue_if.sv
// Decode/issue side handshake bundle of the issue queue.
interface issue_queue_if;
  import issue_queue_pkg::*;

  logic                  flash;
  logic                  stall;
  logic [1:0]            push_number;
  ISSUE_QUEUE_ELEMENT [1:0] push_data;
  logic                  push_ready;
  ISSUE_QUEUE_ELEMENT [1:0] issue_require;
  logic [1:0]            iq_size;
  logic [1:0]            iq_pop_number;

  modport master (
    output flash, stall, push_number, push_data, iq_pop_number,
    input  push_ready, issue_require, iq_size
  );

  modport slave (
    input  flash, stall, push_number, push_data, iq_pop_number,
    output push_ready, issue_require, iq_size
  );

endinterface

// File: rtl/issue_queue.sv
// Dual-push / dual-pop circular issue queue with zero-latency head read.
// Optional occupancy counters under macro ISSUE_QUEUE_PERF_EN.
module issue_queue
  import issue_queue_pkg::*;
#(
  parameter int IQ_DEPTH = IQ_DEPTH_DEFAULT
) (
  input  logic clk,
  input  logic rst,
  issue_queue_if.slave iq
`ifdef ISSUE_QUEUE_PERF_EN
  ,
  output logic [31:0] perf_full_cycles,
  output logic [31:0] perf_empty_cycles
`endif
);

  localparam int PW = $clog2(IQ_DEPTH);
  localparam int CW = PW + 1;

  logic [PW-1:0] head_q, head_d, tail_q, tail_d;
  logic [PW-1:0] head_p1, tail_p1;
  logic [CW-1:0] count_q, count_d;
  ISSUE_QUEUE_ELEMENT mem_q [IQ_DEPTH];

  logic [1:0] size;
  logic [1:0] push_acc;
  logic [1:0] pop_eff;
  bool        push_ready;
  bool        flush;

  assign head_p1    = head_q + PW'(1);
  assign tail_p1    = tail_q + PW'(1);
  assign push_ready = (count_q <= CW'(IQ_DEPTH - 2));
  assign size       = (count_q >= CW'(2)) ? 2'd2 : count_q[1:0];
  assign flush      = iq.flash;

  assign iq.push_ready       = push_ready;
  assign iq.iq_size          = size;
  assign iq.issue_require[0] = (size != 2'd0) ? mem_q[head_q]  : '0;
  assign iq.issue_require[1] = (size == 2'd2) ? mem_q[head_p1] : '0;

  always_comb begin
    push_acc = 2'd0;
    pop_eff  = 2'd0;
    // a push offered while not ready is dropped in full, never split
    if (push_ready && (iq.push_number == 2'd1 || iq.push_number == 2'd2)) begin
      push_acc = iq.push_number;
    end
    if (!iq.stall) begin
      pop_eff = (iq.iq_pop_number < size) ? iq.iq_pop_number : size;
    end

    head_d  = head_q + PW'(pop_eff);
    tail_d  = tail_q + PW'(push_acc);
    count_d = count_q + CW'(push_acc) - CW'(pop_eff);

    if (flush) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // storage is left uncleared; pointers alone define what is valid
  always_ff @(posedge clk) begin
    if (!rst && !flush) begin
      if (push_acc != 2'd0) mem_q[tail_q]  <= iq.push_data[0];
      if (push_acc == 2'd2) mem_q[tail_p1] <= iq.push_data[1];
    end
  end

`ifdef ISSUE_QUEUE_PERF_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_full_cycles  <= '0;
      perf_empty_cycles <= '0;
    end else begin
      if (!push_ready && perf_full_cycles != 32'hFFFF_FFFF) begin
        perf_full_cycles <= perf_full_cycles + 32'd1;
      end
      if (count_q == '0 && perf_empty_cycles != 32'hFFFF_FFFF) begin
        perf_empty_cycles <= perf_empty_cycles + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_issue_queue.sv
// Self-checking bench for issue_queue against a queue-based reference model.
module tb_issue_queue;
  import issue_queue_pkg::*;

  localparam int DEPTH = IQ_DEPTH_DEFAULT;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   n_cmp = 0;
  int   n_err = 0;

  ISSUE_QUEUE_ELEMENT model [$];

  issue_queue_if iq_if ();

`ifdef ISSUE_QUEUE_PERF_EN
  logic [31:0] perf_full_cycles;
  logic [31:0] perf_empty_cycles;
  issue_queue #(.IQ_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .iq(iq_if),
    .perf_full_cycles(perf_full_cycles),
    .perf_empty_cycles(perf_empty_cycles)
  );
`else
  issue_queue #(.IQ_DEPTH(DEPTH)) dut (.clk(clk), .rst(rst), .iq(iq_if));
`endif

  always #5 clk = ~clk;

  function automatic ISSUE_QUEUE_ELEMENT rand_el();
    ISSUE_QUEUE_ELEMENT e;
    e.rob_id = 6'($urandom);
    e.pc     = $urandom;
    e.uop    = 16'($urandom);
    return e;
  endfunction

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs();
    ISSUE_QUEUE_ELEMENT e0, e1;
    int sz;
    sz = (model.size() < 2) ? model.size() : 2;
    e0 = (sz >= 1) ? model[0] : '0;
    e1 = (sz >= 2) ? model[1] : '0;
    chk("push_ready", 128'(iq_if.push_ready), 128'((DEPTH - model.size()) >= 2));
    chk("iq_size",    128'(iq_if.iq_size),    128'(sz));
    chk("issue_req0", 128'(iq_if.issue_require[0]), 128'(e0));
    chk("issue_req1", 128'(iq_if.issue_require[1]), 128'(e1));
  endtask

  // drive one cycle of inputs, advance the model, then check after the edge
  task automatic step(input logic r, input logic fl, input logic st,
                      input logic [1:0] pn, input logic [1:0] pp);
    ISSUE_QUEUE_ELEMENT d0, d1;
    int sz, pop;
    bit rdy;
    d0 = rand_el();
    d1 = rand_el();
    rst                 = r;
    iq_if.flash         = fl;
    iq_if.stall         = st;
    iq_if.push_number   = pn;
    iq_if.push_data     = {d1, d0};
    iq_if.iq_pop_number = pp;
    rdy = (DEPTH - model.size()) >= 2;
    if (r || fl) begin
      model.delete();
    end else begin
      sz  = (model.size() < 2) ? model.size() : 2;
      pop = st ? 0 : ((int'(pp) < sz) ? int'(pp) : sz);
      repeat (pop) void'(model.pop_front());
      if (rdy && (pn == 2'd1 || pn == 2'd2)) model.push_back(d0);
      if (rdy && pn == 2'd2) model.push_back(d1);
    end
    @(posedge clk);
    #1;
    check_outputs();
  endtask

  initial begin
    iq_if.flash = 1'b0;
    iq_if.stall = 1'b0;
    iq_if.push_number = 2'd0;
    iq_if.push_data = '0;
    iq_if.iq_pop_number = 2'd0;
    @(negedge clk);

    // reset, then a pair push becomes visible the next cycle
    step(1, 0, 0, 0, 0);
    step(0, 0, 0, 2, 0);

    // fill to 8, offered push while full is dropped, then drain in order
    step(0, 0, 0, 2, 0);
    step(0, 0, 0, 2, 0);
    step(0, 0, 0, 2, 0);
    step(0, 0, 0, 2, 0);
    step(0, 0, 0, 2, 0);
    for (int i = 0; i < 5; i++) step(0, 0, 0, 0, 2);

    // single entry, pop of two clamps to one
    step(1, 0, 0, 0, 0);
    step(0, 0, 0, 1, 0);
    step(0, 0, 0, 0, 2);

    // hold 6 with simultaneous push/pop across pointer wrap
    step(1, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) step(0, 0, 0, 2, 0);
    for (int i = 0; i < 5; i++) step(0, 0, 0, 2, 2);
    for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 2);

    // stall blocks pops, flash wins over stall and push
    step(1, 0, 0, 0, 0);
    step(0, 0, 0, 2, 0);
    step(0, 0, 0, 2, 0);
    step(0, 0, 1, 2, 2);
    step(0, 1, 1, 2, 2);
    step(0, 0, 0, 3, 3);

    // reset mid-operation loses the in-flight push
    step(0, 0, 0, 2, 0);
    step(1, 0, 0, 2, 1);

`ifdef ISSUE_QUEUE_PERF_EN
    step(1, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) step(0, 0, 0, 2, 0);
    for (int i = 0; i < 5; i++) step(0, 0, 0, 0, 0);
    chk("perf_full",      128'(perf_full_cycles), 128'(5));
    chk("perf_empty_ge3", 128'(perf_empty_cycles >= 32'd3), 128'(1));
`endif

    for (int i = 0; i < 400; i++) begin
      step(($urandom % 60) == 0, ($urandom % 25) == 0, ($urandom % 4) == 0,
           2'($urandom), 2'($urandom));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
